serial_parity_fsm: RTL and testbench
====================================

SERIAL_PARITY_FSM -- requirements
Module: serial_parity_fsm

Interface
REQ-001 Parameter FRAME_LEN, default 3, meaning data bits per frame (SHALL be >= 2).
REQ-002 Parameter ERR_CNT_W, default 8, meaning width of the saturating error counter.
REQ-003 Port clk  input  1  meaning single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 Port din_valid  input  1  meaning din carries a valid serial bit this cycle.
REQ-006 Port din  input  1  meaning serial data bit.
REQ-007 Port odd_sel  input  1  meaning parity mode: 0 = even, 1 = odd; sampled on a frame's first bit.
REQ-008 Port chk_en  input  1  meaning 0 = generate mode, 1 = check mode (frame followed by a received parity bit); sampled on a frame's first bit.
REQ-009 Port busy  output  1  meaning a frame is in progress (state not IDLE).
REQ-010 Port par_valid  output  1  meaning one-cycle pulse: frame complete, par_out and par_err valid.
REQ-011 Port par_out  output  1  meaning generated parity bit.
REQ-012 Port par_err  output  1  meaning parity mismatch in check mode (always 0 in generate mode).
REQ-013 Port err_cnt  output  ERR_CNT_W  meaning count of check-mode frames with par_err = 1, saturating.

Function
REQ-014 States: IDLE, DATA, CHK; bit counter width $clog2(FRAME_LEN+1).
REQ-015 A cycle with din_valid = 0 SHALL leave state, counter, accumulator and latched modes unchanged.
REQ-016 IDLE with din_valid = 1: acc <= din, cnt <= 1, latch odd_sel/chk_en, go to DATA.
REQ-017 DATA with din_valid = 1: acc <= acc ^ din, cnt <= cnt + 1; when cnt + 1 = FRAME_LEN, go to IDLE (generate) or CHK (check).
REQ-018 Generate completion: the cycle after the last data bit is accepted, par_valid = 1, par_out = final acc ^ latched odd, par_err = 0.
REQ-019 CHK with din_valid = 1: the received bit rx is accepted; next cycle par_valid = 1, par_out = acc ^ odd (expected bit), par_err = acc ^ rx ^ odd; state returns to IDLE.
REQ-020 par_out and par_err SHALL hold their last values between par_valid pulses; par_valid is 0 on all other cycles.
REQ-021 Back-to-back frames: a valid bit in the cycle where par_valid = 1 SHALL be accepted as the next frame's first bit; no bubble.
REQ-022 err_cnt SHALL increment by 1 in the par_valid cycle when par_err = 1, and hold at 2^ERR_CNT_W - 1 once reached.
REQ-023 Changes to odd_sel/chk_en mid-frame SHALL NOT affect the current frame.
REQ-024 busy = 1 in DATA and CHK, 0 in IDLE.

Reset
REQ-025 With rst = 1 at a rising edge: state IDLE, cnt 0, acc 0, busy 0, par_valid 0, par_out 0, par_err 0, err_cnt 0.
REQ-026 Reset mid-frame SHALL discard the partial frame with no par_valid pulse; the first valid bit after rst deasserts starts a new frame.
REQ-027 rst SHALL take priority over din_valid in the same cycle.

Structure
REQ-028 Package parity_fsm_pkg SHALL hold the state enum (IDLE, DATA, CHK) and the mode constants EVEN = 0, ODD = 1.
REQ-029 The error counter SHALL be a sub-module sat_counter (parameter WIDTH; ports clk, rst, inc, count).
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 FRAME_LEN = 3, even, generate: frames 000, 111, 001 back-to-back -> par_out 0, 1, 1 on consecutive par_valid pulses spaced 3 cycles apart.
REQ-032 Odd generate: 110 -> par_out 1; 101 with din_valid low for 2 cycles between bits 2 and 3 -> par_valid delayed 2 cycles, par_out 1.
REQ-033 Even check: 101 then rx 0 -> par_err 0, err_cnt 0; 101 then rx 1 -> par_err 1, err_cnt 1.
REQ-034 rst asserted after 2 bits of a frame -> no par_valid; next frame 011 (even) -> par_out 0.
REQ-035 ERR_CNT_W = 2, five failing check frames -> err_cnt 1, 2, 3, 3, 3.
REQ-036 odd_sel toggled 0 -> 1 after the first bit of 111 -> par_out 1 (even parity retained).

Source files
------------

// File: rtl/parity_fsm_pkg.sv
// Shared types and constants for the serial parity generator/checker.
package parity_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2
  } state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // Parity bit for an accumulated XOR under the given mode.
  function automatic logic parity_bit(input logic acc, input logic mode);
    return acc ^ (mode == ODD);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/serial_parity_fsm.sv
// Serial parity generator / checker over fixed-length frames, with a
// saturating count of check-mode parity errors.
module serial_parity_fsm
  import parity_fsm_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic                 din,
  input  logic                 odd_sel,
  input  logic                 chk_en,
  output logic                 busy,
  output logic                 par_valid,
  output logic                 par_out,
  output logic                 par_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic               odd_q, odd_d;
  logic               chk_q, chk_d;
  logic               busy_q, busy_d;
  logic               par_valid_q, par_valid_d;
  logic               par_out_q, par_out_d;
  logic               par_err_q, par_err_d;
  logic               err_inc;

  // Next-state and registered-output logic; idle cycles change nothing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    odd_d       = odd_q;
    chk_d       = chk_q;
    par_valid_d = 1'b0;
    par_out_d   = par_out_q;
    par_err_d   = par_err_q;
    err_inc     = 1'b0;

    if (din_valid) begin
      case (state_q)
        IDLE: begin
          acc_d   = din;
          cnt_d   = CNT_W'(1);
          odd_d   = odd_sel;
          chk_d   = chk_en;
          state_d = DATA;
        end
        DATA: begin
          acc_d = acc_q ^ din;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(FRAME_LEN)) begin
            if (chk_q) begin
              state_d = CHK;
            end else begin
              state_d     = IDLE;
              par_valid_d = 1'b1;
              par_out_d   = parity_bit(acc_d, odd_q);
              par_err_d   = 1'b0;
            end
          end
        end
        CHK: begin
          state_d     = IDLE;
          par_valid_d = 1'b1;
          par_out_d   = parity_bit(acc_q, odd_q);
          par_err_d   = parity_bit(acc_q, odd_q) ^ din;
          err_inc     = par_err_d;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      odd_q       <= EVEN;
      chk_q       <= 1'b0;
      busy_q      <= 1'b0;
      par_valid_q <= 1'b0;
      par_out_q   <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      odd_q       <= odd_d;
      chk_q       <= chk_d;
      busy_q      <= busy_d;
      par_valid_q <= par_valid_d;
      par_out_q   <= par_out_d;
      par_err_q   <= par_err_d;
    end
  end

  // Counter updates on the same edge that raises par_err.
  sat_counter #(
    .WIDTH(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_inc),
    .count(err_cnt)
  );

  assign busy      = busy_q;
  assign par_valid = par_valid_q;
  assign par_out   = par_out_q;
  assign par_err   = par_err_q;

endmodule

// File: tb/tb_serial_parity_fsm.sv
// Bench for serial_parity_fsm: frame table plus hand sequences, with a
// scoreboard of expected par_valid pulses (two counter widths in parallel).
module tb_serial_parity_fsm;
  import parity_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic       din = 1'b0;
  logic       odd_sel = 1'b0;
  logic       chk_en = 1'b0;
  logic       busy_a, par_valid_a, par_out_a, par_err_a;
  logic [7:0] err_cnt_a;
  logic       busy_b, par_valid_b, par_out_b, par_err_b;
  logic [1:0] err_cnt_b;

  serial_parity_fsm #(.FRAME_LEN(3), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .odd_sel(odd_sel), .chk_en(chk_en), .busy(busy_a),
    .par_valid(par_valid_a), .par_out(par_out_a), .par_err(par_err_a),
    .err_cnt(err_cnt_a)
  );

  serial_parity_fsm #(.FRAME_LEN(3), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .odd_sel(odd_sel), .chk_en(chk_en), .busy(busy_b),
    .par_valid(par_valid_b), .par_out(par_out_b), .par_err(par_err_b),
    .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame bits are sent MSB first: 3'b001 means 0, 0, then 1.
  typedef struct {
    logic [2:0] bits;
    logic       odd;
    logic       chk;
    logic       rx;
    int         gap;
    logic       flip;
    logic       po;
    logic       pe;
  } vec_t;

  typedef struct {
    int         due;
    logic       po;
    logic       pe;
    logic [7:0] ea;
    logic [1:0] eb;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_ea = 8'd0;
  logic [1:0] m_eb = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulses must arrive exactly on the cycle recorded when the last bit was driven.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL par_valid_missing: no pulse, expected at cycle %0d", sb[0].due);
      void'(sb.pop_front());
    end
    if (par_valid_a) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL par_valid_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        e = sb.pop_front();
        check("par_out", 32'(par_out_a), 32'(e.po));
        check("par_err", 32'(par_err_a), 32'(e.pe));
        check("err_cnt_w8", 32'(err_cnt_a), 32'(e.ea));
        check("err_cnt_w2", 32'(err_cnt_b), 32'(e.eb));
        check("par_valid_b", 32'(par_valid_b), 32'd1);
      end
    end
  end

  task automatic step(input logic v, input logic d, input logic o, input logic c);
    @(negedge clk);
    din_valid = v;
    din       = d;
    odd_sel   = o;
    chk_en    = c;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
  endtask

  task automatic expect_frame(input logic po, input logic pe);
    if (pe) begin
      if (m_ea != 8'hFF) m_ea = m_ea + 8'd1;
      if (m_eb != 2'd3)  m_eb = m_eb + 2'd1;
    end
    sb.push_back('{cyc + 1, po, pe, m_ea, m_eb});
  endtask

  // Gap cycles (din_valid low, noisy inputs) go before the last data bit.
  task automatic send_frame(input vec_t v);
    logic o, c;
    for (int i = 2; i >= 0; i--) begin
      if (i == 0) idle(v.gap);
      o = (i != 2 && v.flip) ? ~v.odd : v.odd;
      c = (i != 2 && v.flip) ? ~v.chk : v.chk;
      step(1'b1, v.bits[i], o, c);
      if (i == 0 && !v.chk) expect_frame(v.po, 1'b0);
    end
    if (v.chk) begin
      step(1'b1, v.rx, v.flip ? ~v.odd : v.odd, v.flip ? ~v.chk : v.chk);
      expect_frame(v.po, v.pe);
    end
  endtask

  // din_valid held high during reset to confirm reset wins.
  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    din_valid = 1'b1;
    din       = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_par_valid", 32'(par_valid_a), 32'd0);
    check("rst_par_out", 32'(par_out_a), 32'd0);
    check("rst_par_err", 32'(par_err_a), 32'd0);
    check("rst_err_cnt_w8", 32'(err_cnt_a), 32'd0);
    check("rst_err_cnt_w2", 32'(err_cnt_b), 32'd0);
    rst       = 1'b0;
    din_valid = 1'b0;
    sb.delete();
    m_ea = 8'd0;
    m_eb = 2'd0;
  endtask

  vec_t tbl[11];
  vec_t fail_frame;

  initial begin
    //          bits    odd   chk   rx    gap flip  po    pe
    tbl = '{
      '{3'b000, EVEN, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0},
      '{3'b111, EVEN, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0},
      '{3'b001, EVEN, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0},
      '{3'b110, ODD,  1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0},
      '{3'b101, ODD,  1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0},
      '{3'b101, EVEN, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0},
      '{3'b101, EVEN, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1},
      '{3'b111, EVEN, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0},
      '{3'b110, ODD,  1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0},
      '{3'b000, ODD,  1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1},
      '{3'b011, ODD,  1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1}
    };

    do_reset();
    idle(1);

    // All table frames back to back: each first bit lands in the previous pulse cycle.
    for (int k = 0; k < 11; k++) send_frame(tbl[k]);
    idle(3);

    // Odd 000 leaves par_out = 1, then a partial frame is killed by reset.
    send_frame('{3'b000, ODD, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0});
    step(1'b1, 1'b0, EVEN, 1'b0);
    step(1'b1, 1'b1, EVEN, 1'b0);
    step(1'b0, 1'b0, EVEN, 1'b0);
    check("busy_mid_frame", 32'(busy_a), 32'd1);
    do_reset();
    send_frame('{3'b011, EVEN, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0});
    idle(3);
    check("busy_after_frame", 32'(busy_a), 32'd0);

    // Five failing check frames: narrow counter saturates at 3.
    do_reset();
    fail_frame = '{3'b101, EVEN, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) send_frame(fail_frame);
    idle(3);
    check("sat_err_cnt_w2", 32'(err_cnt_b), 32'd3);
    check("sat_err_cnt_w8", 32'(err_cnt_a), 32'd5);
    check("par_err_held", 32'(par_err_a), 32'd1);

    idle(2);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
